// File: rtl/plot_sequencer.sv
// plot_sequencer: queues plot requests for vga_adapter, filters out-of-range (and, with
// PLOT_DEDUP_EN defined, repeated) requests, and runs a full-screen clear sweep.
module plot_sequencer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned X_MAX      = 159,
    parameter int unsigned Y_MAX      = 119
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_x,
    input  logic [6:0]  in_y,
    input  logic [2:0]  in_colour,
    output logic        in_ready,
    input  logic        clear_req,
    input  logic [2:0]  clear_colour,
    output logic        clearing,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic [15:0] drop_count
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  X_LIM = 8'(X_MAX);
    localparam logic [6:0]  Y_LIM = 7'(Y_MAX);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;
    state_t state_reg, state_next;

    logic [17:0] mem [0:FIFO_DEPTH-1];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic        full, empty;
    logic [17:0] req;
    logic        consume, in_range, is_dup, push, pop, drop;
    logic        sweep_last, drain_done;
    logic [2:0]  clear_colour_reg;
    logic [7:0]  sweep_x_reg;
    logic [6:0]  sweep_y_reg;
    logic [7:0]  x_reg;
    logic [6:0]  y_reg;
    logic [2:0]  colour_reg;
    logic        plot_reg, clearing_reg;
    logic [15:0] drop_count_reg;

    assign req      = {in_x, in_y, in_colour};
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign in_range = (in_x <= X_LIM) && (in_y <= Y_LIM);
    assign consume  = in_valid && in_ready;
    assign push     = consume && in_range && !is_dup;
    assign drop     = consume && !(in_range && !is_dup);

    assign sweep_last = (state_reg == CLEAR) && (sweep_x_reg == X_LIM) && (sweep_y_reg == Y_LIM);
    assign drain_done = (state_reg == DRAIN) && empty;

    assign x          = x_reg;
    assign y          = y_reg;
    assign colour     = colour_reg;
    assign plot       = plot_reg;
    assign clearing   = clearing_reg;
    assign drop_count = drop_count_reg;

`ifdef PLOT_DEDUP_EN
    logic        dedup_valid_reg;
    logic [17:0] dedup_reg;

    assign is_dup = dedup_valid_reg && (dedup_reg == req);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            dedup_valid_reg <= 1'b0;
            dedup_reg       <= 18'd0;
        end else if (drain_done) begin
            dedup_valid_reg <= 1'b0;
        end else if (push) begin
            dedup_valid_reg <= 1'b1;
            dedup_reg       <= req;
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        pop        = 1'b0;
        case (state_reg)
            RUN: begin
                in_ready = !full;
                pop      = !empty;
                if (clear_req) state_next = DRAIN;
            end
            DRAIN: begin
                pop = !empty;
                if (empty) state_next = CLEAR;
            end
            CLEAR: begin
                // Requests keep queueing behind the sweep; nothing pops until it ends.
                in_ready = !full;
                if (sweep_last) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) state_reg <= RUN;
        else       state_reg <= state_next;
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= req;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            x_reg            <= 8'd0;
            y_reg            <= 7'd0;
            colour_reg       <= 3'd0;
            plot_reg         <= 1'b0;
            clearing_reg     <= 1'b0;
            drop_count_reg   <= 16'd0;
            clear_colour_reg <= 3'd0;
            sweep_x_reg      <= 8'd0;
            sweep_y_reg      <= 7'd0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            if (drop && (drop_count_reg != 16'hFFFF)) drop_count_reg <= drop_count_reg + 16'd1;

            plot_reg <= 1'b0;
            if (pop) begin
                {x_reg, y_reg, colour_reg} <= mem[rd_ptr_reg[AW-1:0]];
                plot_reg <= 1'b1;
            end else if (state_reg == CLEAR) begin
                x_reg      <= sweep_x_reg;
                y_reg      <= sweep_y_reg;
                colour_reg <= clear_colour_reg;
                plot_reg   <= 1'b1;
                if (sweep_x_reg == X_LIM) begin
                    sweep_x_reg <= 8'd0;
                    sweep_y_reg <= sweep_y_reg + 7'd1;
                end else begin
                    sweep_x_reg <= sweep_x_reg + 8'd1;
                end
            end

            if ((state_reg == RUN) && clear_req) begin
                clear_colour_reg <= clear_colour;
                clearing_reg     <= 1'b1;
            end
            if (drain_done) begin
                sweep_x_reg <= 8'd0;
                sweep_y_reg <= 7'd0;
            end
            if (sweep_last) clearing_reg <= 1'b0;
        end
    end
endmodule

// File: tb/tb_plot_sequencer.sv
// Self-checking bench for plot_sequencer: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based behavioural model.
module tb_plot_sequencer;
    localparam int DEPTH  = 8;
    localparam int X_MAX  = 159;
    localparam int Y_MAX  = 119;
    localparam int PIXELS = (X_MAX + 1) * (Y_MAX + 1);
    localparam int M_RUN = 0, M_DRAIN = 1, M_CLEAR = 2;
`ifdef PLOT_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic        CLOCK_50, reset, in_valid, in_ready, clear_req, clearing, plot;
    logic [7:0]  in_x, x;
    logic [6:0]  in_y, y;
    logic [2:0]  in_colour, clear_colour, colour;
    logic [15:0] drop_count;

    plot_sequencer dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
        .in_colour(in_colour), .in_ready(in_ready), .clear_req(clear_req),
        .clear_colour(clear_colour), .clearing(clearing), .x(x), .y(y), .colour(colour),
        .plot(plot), .drop_count(drop_count)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference model state
    logic [17:0] q[$];
    int          mode, idx, drops;
    bit          dvalid, e_plot, e_clearing, last_acc;
    logic [17:0] dval;
    logic [2:0]  clr;
    logic [7:0]  e_x;
    logic [6:0]  e_y;
    logic [2:0]  e_c;
    int          n_pass, n_checks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic set_req(input bit v, input int rx, input int ry, input int rc);
        in_valid  = v;
        in_x      = 8'(rx);
        in_y      = 7'(ry);
        in_colour = 3'(rc);
    endtask

    // One clock: predict in_ready, advance the model, then check registered outputs.
    task automatic cycle();
        bit          rdy, acc, pop, inr, dup;
        logic [17:0] r;
        rdy = (mode != M_DRAIN) && (q.size() < DEPTH);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        acc = in_valid && rdy;
        r   = {in_x, in_y, in_colour};
        pop = (mode != M_CLEAR) && (q.size() != 0);
        e_plot = 1'b0;
        if (pop) begin
            {e_x, e_y, e_c} = q.pop_front();
            e_plot = 1'b1;
        end else if (mode == M_CLEAR) begin
            e_x = 8'(idx % (X_MAX + 1));
            e_y = 7'(idx / (X_MAX + 1));
            e_c = clr;
            e_plot = 1'b1;
        end
        if (acc) begin
            inr = (int'(in_x) <= X_MAX) && (int'(in_y) <= Y_MAX);
            dup = DEDUP && dvalid && (dval == r);
            if (inr && !dup) begin
                q.push_back(r);
                dvalid = 1'b1;
                dval   = r;
            end else if (drops < 65535) begin
                drops++;
            end
            $display("req x=%0d y=%0d c=%0d -> %s", in_x, in_y, in_colour,
                     (inr && !dup) ? "queued" : "dropped");
        end
        case (mode)
            M_RUN: if (clear_req) begin
                mode = M_DRAIN;
                clr = clear_colour;
                e_clearing = 1'b1;
            end
            M_DRAIN: if (!pop) begin
                mode = M_CLEAR;
                idx = 0;
                dvalid = 1'b0;
            end
            default: begin
                idx++;
                if (idx == PIXELS) begin
                    mode = M_RUN;
                    e_clearing = 1'b0;
                end
            end
        endcase
        last_acc = acc;
        @(posedge CLOCK_50);
        #1;
        chk("plot", 32'(plot), 32'(e_plot));
        chk("clearing", 32'(clearing), 32'(e_clearing));
        chk("drop_count", 32'(drop_count), 32'(drops));
        if (e_plot) begin
            chk("x", 32'(x), 32'(e_x));
            chk("y", 32'(y), 32'(e_y));
            chk("colour", 32'(colour), 32'(e_c));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; clear_req = 1'b0;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        q.delete();
        mode = M_RUN; idx = 0; drops = 0; dvalid = 1'b0; last_acc = 1'b0;
        e_plot = 1'b0; e_clearing = 1'b0;
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_clearing", 32'(clearing), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_colour", 32'(colour), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [17:0] obs[$];
        logic [17:0] reqs[10];
        int          k, cnt, d0, sweep_n, first_nz, last_z, nz;

        n_pass = 0; n_checks = 0;
        reset = 1'b1; clear_req = 1'b0; clear_colour = 3'd0;
        set_req(0, 0, 0, 0);
        repeat (2) @(posedge CLOCK_50);
        #1;
        do_reset();

        // 1: single request, one-cycle latency
        set_req(1, 10, 20, 1); cycle();
        in_valid = 1'b0; cycle();
        chk("t1_plot", 32'(plot), 32'd1);
        chk("t1_xy", 32'({x, y, colour}), 32'({8'd10, 7'd20, 3'd1}));
        cycle();
        chk("t1_after", 32'(plot), 32'd0);

        // 2: same request held valid for five cycles
        cnt = 0;
        set_req(1, 5, 5, 2);
        for (int i = 0; i < 8; i++) begin
            if (i == 5) in_valid = 1'b0;
            cycle();
            if (plot) cnt++;
        end
        chk("t2_plots", 32'(cnt), DEDUP ? 32'd1 : 32'd5);
        chk("t2_drops", 32'(drop_count), DEDUP ? 32'd4 : 32'd0);

        // 3: out-of-range requests
        d0 = int'(drop_count);
        cnt = 0;
        set_req(1, 160, 0, 3); cycle(); if (plot) cnt++;
        set_req(1, 0, 120, 3); cycle(); if (plot) cnt++;
        in_valid = 1'b0;
        repeat (2) begin cycle(); if (plot) cnt++; end
        chk("t3_plots", 32'(cnt), 32'd0);
        chk("t3_drops", 32'(drop_count), 32'(d0 + 2));

        // 4: clear sweep with ten requests arriving behind it
        for (int i = 0; i < 10; i++) reqs[i] = {8'(i * 3), 7'(i + 1), 3'((i % 7) + 1)};
        clear_colour = 3'd0; clear_req = 1'b1; cycle();
        clear_req = 1'b0;
        k = 0;
        obs.delete();
        for (int i = 0; i < 19400; i++) begin
            if (k < 10) set_req(1, int'(reqs[k][17:10]), int'(reqs[k][9:3]), int'(reqs[k][2:0]));
            else in_valid = 1'b0;
            if ((mode == M_CLEAR) && (idx == 10000)) chk("t4_full_block", 32'(in_ready), 32'd0);
            cycle();
            if (last_acc) k++;
            if (plot) obs.push_back({x, y, colour});
        end
        sweep_n = 0; first_nz = -1; last_z = -1; nz = 0;
        foreach (obs[i]) begin
            if (obs[i][2:0] == 3'd0) begin
                if (sweep_n == 0) chk("t4_first_px", 32'(obs[i]), 32'd0);
                sweep_n++;
                last_z = i;
            end else begin
                if (first_nz < 0) first_nz = i;
                if (nz < 10) chk("t4_backlog_order", 32'(obs[i]), 32'(reqs[nz]));
                nz++;
            end
        end
        chk("t4_sweep_len", 32'(sweep_n), 32'(PIXELS));
        chk("t4_last_px", 32'(obs[last_z]), 32'({8'd159, 7'd119, 3'd0}));
        chk("t4_backlog_n", 32'(nz), 32'd10);
        chk("t4_after_sweep", 32'(first_nz > last_z), 32'd1);

        // 5: request and clear on the same edge
        clear_colour = 3'd5;
        set_req(1, 30, 40, 4); clear_req = 1'b1; cycle();
        in_valid = 1'b0; clear_req = 1'b0;
        chk("t5_clearing", 32'(clearing), 32'd1);
        cycle();
        chk("t5_req_first", 32'({plot, x, y, colour}), 32'({1'b1, 8'd30, 7'd40, 3'd4}));
        cycle();
        cycle();
        chk("t5_px0", 32'({plot, x, y, colour}), 32'({1'b1, 8'd0, 7'd0, 3'd5}));
        for (int i = 0; i < 19300; i++) cycle();

        // 6: reset in the middle of a sweep
        clear_colour = 3'd2; clear_req = 1'b1; cycle();
        clear_req = 1'b0;
        for (int i = 0; i < 6000 && !((mode == M_CLEAR) && (idx == 5000)); i++) cycle();
        chk("t6_mid_sweep", 32'(clearing), 32'd1);
        do_reset();
        set_req(1, 7, 8, 3); cycle();
        in_valid = 1'b0; cycle();
        chk("t6_new_req", 32'({plot, x, y, colour}), 32'({1'b1, 8'd7, 7'd8, 3'd3}));
        cycle();

        // Random traffic with one clear (clear_req held a few cycles) in the middle
        for (int i = 0; i < 21000; i++) begin
            if (!(in_valid && !last_acc)) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_x      = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(157, 255))
                                                        : 8'($urandom_range(0, 3));
                in_y      = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(118, 127))
                                                        : 7'($urandom_range(0, 3));
                in_colour = 3'($urandom_range(0, 1));
            end
            if (i == 300) clear_colour = 3'($urandom_range(0, 7));
            clear_req = (i >= 300) && (i < 303);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
